// File: rtl/tdfc_vsum_d1_pkg.sv
// ----------------------------------------------------------------------------
// tdfc_vsum_d1_pkg
// Shared definitions for the vector-sum reduction stage:
//   - default element / accumulator widths
//   - FSM state encoding
//   - control bus carried from the FSM to the datapath
// ----------------------------------------------------------------------------
package tdfc_vsum_d1_pkg;

   localparam int DW_DEF = 8;    // input element width
   localparam int SW_DEF = 16;   // accumulator / output sum width

   typedef enum logic [1:0] {
      ST_ACC      = 2'd0,   // accumulating input elements
      ST_EMIT_SUM = 2'd1,   // presenting the scalar sum token
      ST_EMIT_EOS = 2'd2    // presenting the trailing eos token
   } state_t;

   // Everything the datapath needs to know about the current cycle.
   typedef struct packed {
      state_t state;      // current FSM state
      logic   data_take;  // input data element accepted this cycle
      logic   eos_take;   // input eos token accepted this cycle
      logic   out_take;   // output token consumed this cycle
   } ctl_bus_t;

endpackage

// File: rtl/tdfc_vsum_d1_dp.sv
// ----------------------------------------------------------------------------
// tdfc_vsum_d1_dp
// Datapath half of the vector-sum stage: the running accumulator and the
// registered output sum.
// Ports:
//   clock  - clock, rising edge
//   reset  - asynchronous active-low reset
//   z_d    - input element data
//   ctl    - control bus from the FSM
//   s_d    - output sum data (registered)
// ----------------------------------------------------------------------------
module tdfc_vsum_d1_dp
   import tdfc_vsum_d1_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] z_d,
   input  ctl_bus_t      ctl,
   output logic [SW-1:0] s_d
);

   logic [SW-1:0] r_acc;
   logic [SW-1:0] r_s_d;
   logic [SW-1:0] w_z_ext;

   // Elements are unsigned; the sum wraps modulo 2^SW.
   assign w_z_ext = SW'(z_d);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_acc <= '0;
         r_s_d <= '0;
      end else begin
         // An eos hand-off and a data accept can never coincide, since both
         // come from the same single input handshake.
         if (ctl.eos_take) begin
            r_s_d <= r_acc;
            r_acc <= '0;
         end else if (ctl.data_take) begin
            r_acc <= r_acc + w_z_ext;
         end
         // Once the sum token is consumed the eos token carries zero data.
         if (ctl.out_take && (ctl.state == ST_EMIT_SUM)) begin
            r_s_d <= '0;
         end
      end
   end

   assign s_d = r_s_d;

endmodule

// File: rtl/tdfc_vsum_d1_fsm.sv
// ----------------------------------------------------------------------------
// tdfc_vsum_d1_fsm
// Control half of the vector-sum stage. Holds the state register, decodes
// input/output handshakes and produces the stream flags.
// Ports:
//   clock  - clock, rising edge
//   reset  - asynchronous active-low reset
//   z_e    - input eos flag
//   z_v    - input token valid
//   z_b    - busy to producer (decode of state only)
//   s_e    - output eos flag (registered)
//   s_v    - output token valid (registered)
//   s_b    - busy from consumer
//   ctl    - control bus to the datapath
// ----------------------------------------------------------------------------
module tdfc_vsum_d1_fsm
   import tdfc_vsum_d1_pkg::*;
(
   input  logic     clock,
   input  logic     reset,
   input  logic     z_e,
   input  logic     z_v,
   output logic     z_b,
   output logic     s_e,
   output logic     s_v,
   input  logic     s_b,
   output ctl_bus_t ctl
);

   state_t r_state;
   state_t w_state_next;
   logic   r_s_v;
   logic   r_s_e;
   logic   w_z_take;
   logic   w_s_take;

   // State register. The output flags are registered from the next state so
   // that they line up exactly with the state they describe.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_ACC;
         r_s_v   <= 1'b0;
         r_s_e   <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_s_v   <= (w_state_next != ST_ACC);
         r_s_e   <= (w_state_next == ST_EMIT_EOS);
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_ACC: begin
            if (w_z_take && z_e) w_state_next = ST_EMIT_SUM;
         end
         ST_EMIT_SUM: begin
            if (w_s_take) w_state_next = ST_EMIT_EOS;
         end
         ST_EMIT_EOS: begin
            if (w_s_take) w_state_next = ST_ACC;
         end
         default: w_state_next = ST_ACC;
      endcase
   end

   // Output / handshake decode. z_b depends on state only, so there is no
   // combinational path from s_b back to the producer.
   always_comb begin
      z_b           = (r_state != ST_ACC);
      w_z_take      = z_v & ~z_b;
      w_s_take      = r_s_v & ~s_b;
      ctl.state     = r_state;
      ctl.data_take = w_z_take & ~z_e;
      ctl.eos_take  = w_z_take & z_e;
      ctl.out_take  = w_s_take;
   end

   assign s_v = r_s_v;
   assign s_e = r_s_e;

endmodule

// File: rtl/tdfc_vsum_d1.sv
// ----------------------------------------------------------------------------
// tdfc_vsum_d1
// Streaming vector-sum reduction. Accumulates the unsigned elements of each
// eos-delimited input vector and emits the scalar sum followed by an eos
// token on the output stream.
// Ports:
//   clock  - clock, rising edge
//   reset  - asynchronous active-low reset
//   z_d    - input element data (ignored on eos tokens)
//   z_e    - input eos flag
//   z_v    - input token valid
//   z_b    - busy to producer
//   s_d    - output sum data
//   s_e    - output eos flag
//   s_v    - output token valid
//   s_b    - busy from consumer
// ----------------------------------------------------------------------------
module tdfc_vsum_d1
   import tdfc_vsum_d1_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int SW = SW_DEF
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [DW-1:0] z_d,
   input  logic          z_e,
   input  logic          z_v,
   output logic          z_b,
   output logic [SW-1:0] s_d,
   output logic          s_e,
   output logic          s_v,
   input  logic          s_b
);

   ctl_bus_t w_ctl;

   tdfc_vsum_d1_fsm u_fsm (
      .clock (clock),
      .reset (reset),
      .z_e   (z_e),
      .z_v   (z_v),
      .z_b   (z_b),
      .s_e   (s_e),
      .s_v   (s_v),
      .s_b   (s_b),
      .ctl   (w_ctl)
   );

   tdfc_vsum_d1_dp #(
      .DW (DW),
      .SW (SW)
   ) u_dp (
      .clock (clock),
      .reset (reset),
      .z_d   (z_d),
      .ctl   (w_ctl),
      .s_d   (s_d)
   );

endmodule
